cv32e40p_ft_pipe_stage: RTL

// - Generic, parametrised fault-tolerant pipeline stage register for the FT core (ID/EX, EX/WB, ...).
// - Valid/ready handshake with a 2-entry skid buffer, synchronous flush, in-place replay (misaligned second phase).
// - Free-running FT sideband (mux selects, clock enables) with optional TMR voting.
// - Per-entry parity check that reports upset events.

---
 rtl/cv32e40p_ft_pipe_stage_if.sv | 37 +++
 rtl/cv32e40p_ft_pipe_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cv32e40p_ft_pipe_stage_if.sv
// Handshake/bus bundle for cv32e40p_ft_pipe_stage.
// slave  : view of the pipeline stage itself (consumes in_*, drives out_*).
// master : view of the surrounding logic (drives in_*, out_ready_i, flush, replay).
// Signals: flush_i, in_valid_i/in_ready_o/in_data_i/in_side_i,
//          out_valid_o/out_ready_i/out_data_o/out_side_o,
//          replay_i/replay_mask_i/replay_data_i, err_o, err_cnt_o.
interface cv32e40p_ft_pipe_stage_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SIDE_W = 7
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic [SIDE_W-1:0] in_side_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [SIDE_W-1:0] out_side_o;
  logic              replay_i;
  logic [DATA_W-1:0] replay_mask_i;
  logic [DATA_W-1:0] replay_data_i;
  logic              err_o;
  logic [7:0]        err_cnt_o;

  modport slave (
    input  flush_i, in_valid_i, in_data_i, in_side_i, out_ready_i,
           replay_i, replay_mask_i, replay_data_i,
    output in_ready_o, out_valid_o, out_data_o, out_side_o, err_o, err_cnt_o
  );

  modport master (
    output flush_i, in_valid_i, in_data_i, in_side_i, out_ready_i,
           replay_i, replay_mask_i, replay_data_i,
    input  in_ready_o, out_valid_o, out_data_o, out_side_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/cv32e40p_ft_pipe_stage.sv
// Fault-tolerant pipeline stage register (head + skid entry).
// - Valid/ready handshake; in_ready_o is registered (= skid entry empty),
//   so there is no combinational path from out_ready_i to in_ready_o.
// - Synchronous flush clears both entries; data registers keep their contents.
// - Replay patches the head entry in place under a bit mask.
// - Sideband sampled every cycle, optionally held in 3 copies and voted.
// - Each entry carries an even-parity bit; a mismatch on the head raises err_o
//   one cycle later and bumps a saturating counter.
// Ports: clk, rst_n (async, active low), bus (slave modport of the _if).
module cv32e40p_ft_pipe_stage #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned SIDE_W   = 7,
  parameter bit          TMR_SIDE = 1'b1,
  parameter bit          PARITY   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cv32e40p_ft_pipe_stage_if.slave bus
);

  function automatic logic f_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  logic              r_h_valid, r_h_par, r_s_valid, r_s_par, r_in_ready, r_err;
  logic [DATA_W-1:0] r_h_data, r_s_data;
  logic [7:0]        r_err_cnt;
  logic [SIDE_W-1:0] r_side0;
  logic [SIDE_W-1:0] w_side_vote;

  logic              w_accept, w_fire, w_pop, w_replay, w_err;
  logic              w_h_valid, w_h_par, w_s_valid, w_s_par;
  logic [DATA_W-1:0] w_h_data, w_s_data, w_patch;

  assign w_accept = bus.in_valid_i & r_in_ready;
  assign w_fire   = r_h_valid & bus.out_ready_i;
  assign w_pop    = w_fire & ~bus.replay_i;
  assign w_replay = w_fire & bus.replay_i;
  assign w_patch  = (r_h_data & ~bus.replay_mask_i) | (bus.replay_data_i & bus.replay_mask_i);
  // Head is still forwarded on a mismatch; the consumer decides what to do.
  assign w_err    = PARITY && r_h_valid && (f_parity(r_h_data) != r_h_par);

  // Next-state of head/skid entries: flush > pop > replay/accept.
  always_comb begin
    w_h_valid = r_h_valid;
    w_h_data  = r_h_data;
    w_h_par   = r_h_par;
    w_s_valid = r_s_valid;
    w_s_data  = r_s_data;
    w_s_par   = r_s_par;
    if (bus.flush_i) begin
      w_h_valid = 1'b0;
      w_s_valid = 1'b0;
    end else if (w_pop) begin
      // Skid valid implies in_ready_o=0, so no accept can coincide with this move.
      if (r_s_valid) begin
        w_h_data  = r_s_data;
        w_h_par   = r_s_par;
        w_s_valid = 1'b0;
      end else if (w_accept) begin
        w_h_data  = bus.in_data_i;
        w_h_par   = f_parity(bus.in_data_i);
      end else begin
        w_h_valid = 1'b0;
      end
    end else begin
      if (w_replay) begin
        w_h_data = w_patch;
        w_h_par  = f_parity(w_patch);
      end else begin
        w_h_data = r_h_data;
      end
      if (w_accept) begin
        if (r_h_valid) begin
          w_s_valid = 1'b1;
          w_s_data  = bus.in_data_i;
          w_s_par   = f_parity(bus.in_data_i);
        end else begin
          w_h_valid = 1'b1;
          w_h_data  = bus.in_data_i;
          w_h_par   = f_parity(bus.in_data_i);
        end
      end else begin
        w_s_valid = r_s_valid;
      end
    end
  end

  // Entry storage, ready flag and parity error reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_valid  <= 1'b0;
      r_h_data   <= {DATA_W{1'b0}};
      r_h_par    <= 1'b0;
      r_s_valid  <= 1'b0;
      r_s_data   <= {DATA_W{1'b0}};
      r_s_par    <= 1'b0;
      r_in_ready <= 1'b1;
      r_err      <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_h_valid  <= w_h_valid;
      r_h_data   <= w_h_data;
      r_h_par    <= w_h_par;
      r_s_valid  <= w_s_valid;
      r_s_data   <= w_s_data;
      r_s_par    <= w_s_par;
      r_in_ready <= ~w_s_valid;
      r_err      <= w_err;
      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  // Sideband copy 0: free-running, ignores handshake and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_side0 <= {SIDE_W{1'b0}};
    end else begin
      r_side0 <= bus.in_side_i;
    end
  end

  generate
    if (TMR_SIDE) begin : g_tmr
      logic [SIDE_W-1:0] r_side1, r_side2;

      // Redundant sideband copies; rewriting every cycle scrubs any upset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_side1 <= {SIDE_W{1'b0}};
          r_side2 <= {SIDE_W{1'b0}};
        end else begin
          r_side1 <= bus.in_side_i;
          r_side2 <= bus.in_side_i;
        end
      end

      assign w_side_vote = (r_side0 & r_side1) | (r_side0 & r_side2) | (r_side1 & r_side2);
    end else begin : g_single
      assign w_side_vote = r_side0;
    end
  endgenerate

  assign bus.in_ready_o  = r_in_ready;
  assign bus.out_valid_o = r_h_valid;
  assign bus.out_data_o  = r_h_data;
  assign bus.out_side_o  = w_side_vote;
  assign bus.err_o       = r_err;
  assign bus.err_cnt_o   = r_err_cnt;

endmodule
